// File: rtl/run_pkg.sv
// -----------------------------------------------------------------------------
// run_pkg
// Shared definitions for the program-run sequencer (run_ctrl) and its stall
// detector (pc_stall_det): run state encoding, default widths and the default
// end-of-program PC value.
// -----------------------------------------------------------------------------
package run_pkg;

    // Default core program-counter width and run-cycle counter width.
    localparam int unsigned DEF_PC_W  = 8;
    localparam int unsigned DEF_CNT_W = 16;

    // Default PC value that marks program end (all ones at the default width).
    localparam logic [DEF_PC_W-1:0] DEF_DONE_PC = '1;

    // Reset-phase counter holds RST_CYCLES-1, so RST_CYCLES up to 15 fits.
    localparam int unsigned RST_CNT_W = 4;

    // Stall counter covers STALL_CYCLES up to 255.
    localparam int unsigned STALL_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RESET_CORE = 2'd1,
        ST_RUN        = 2'd2,
        ST_DONE       = 2'd3
    } run_state_e;

endpackage : run_pkg

// File: rtl/pc_stall_det.sv
// -----------------------------------------------------------------------------
// pc_stall_det
// Detects a core that has stopped advancing: remembers the previous RUN-cycle
// PC and counts consecutive RUN cycles in which the PC did not change.
//
// Ports:
//   clk      in   1             system clock, rising edge
//   rst      in   1             asynchronous, active-high reset
//   run      in   1             sequencer is in RUN this cycle
//   pc       in   PC_W          core program counter
//   stalled  out  1             PC has been held for STALL_CYCLES RUN cycles
//                               (this cycle included)
// -----------------------------------------------------------------------------
module pc_stall_det
    import run_pkg::*;
#(
    parameter int unsigned PC_W         = DEF_PC_W,
    parameter int unsigned STALL_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [PC_W-1:0] pc,
    output logic            stalled
);

    logic [PC_W-1:0]        prev_pc;
    logic                   prev_valid;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   pc_same;

    // prev_valid is low on the first RUN cycle, so a stale PC left over from an
    // earlier run can never be mistaken for a stall.
    assign pc_same = prev_valid && (pc == prev_pc);

    // stall_cnt counts earlier equal comparisons; this cycle's equal comparison
    // is the one that brings the count to STALL_CYCLES-1.
    assign stalled = run && pc_same &&
                     (stall_cnt == STALL_CNT_W'(STALL_CYCLES - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            stall_cnt  <= '0;
        end else if (run) begin
            prev_pc    <= pc;
            prev_valid <= 1'b1;
            if (!pc_same)
                stall_cnt <= '0;
            else if (stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end else begin
            prev_valid <= 1'b0;
            stall_cnt  <= '0;
        end
    end

endmodule : pc_stall_det

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
// Program-run sequencer between the bench-level start/done handshake and the
// processor core reset. A rising edge on start launches a run: the core is
// held in reset for RST_CYCLES cycles, then released until it halts (PC
// reaches DONE_PC, or, with HALT_MODE = 1, the PC stops changing). done is
// sticky until the next launch; cycle_count reports the RUN cycles of the
// last/current run.
//
// Optional feature: define RUN_WATCHDOG_EN to end a run after MAX_CYCLES RUN
// cycles with timeout = 1. Without it timeout is tied low.
//
// Ports:
//   clk          in   1       system clock, rising edge
//   rst          in   1       asynchronous, active-high reset
//   start        in   1       run request; only its rising edge is acted on
//   pc           in   PC_W    core program counter
//   core_rst     out  1       reset to core, active-high
//   busy         out  1       high while resetting or running the core
//   done         out  1       sticky completion flag
//   timeout      out  1       run ended by watchdog
//   cycle_count  out  CNT_W   RUN cycles of the last/current run (saturating)
// -----------------------------------------------------------------------------
module run_ctrl
    import run_pkg::*;
#(
    parameter int unsigned      PC_W         = DEF_PC_W,
    parameter logic [PC_W-1:0]  DONE_PC      = {PC_W{1'b1}},
    parameter int unsigned      RST_CYCLES   = 2,
    parameter int unsigned      HALT_MODE    = 0,
    parameter int unsigned      STALL_CYCLES = 4,
    parameter int unsigned      CNT_W        = DEF_CNT_W,
    parameter logic [CNT_W-1:0] MAX_CYCLES   = 16'hFFF0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PC_W-1:0]  pc,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    // Elaboration-time parameter range checks.
    if (RST_CYCLES < 1 || RST_CYCLES > 15) begin : g_bad_rst_cycles
        $error("run_ctrl: RST_CYCLES must be 1..15");
    end
    if (STALL_CYCLES < 2 || STALL_CYCLES > 255) begin : g_bad_stall_cycles
        $error("run_ctrl: STALL_CYCLES must be 2..255");
    end
    if (HALT_MODE > 1) begin : g_bad_halt_mode
        $error("run_ctrl: HALT_MODE must be 0 or 1");
    end
    if (MAX_CYCLES == '0) begin : g_bad_max_cycles
        $error("run_ctrl: MAX_CYCLES must be non-zero");
    end

    run_state_e           state, state_next;
    logic                 start_q;
    logic                 start_edge;
    logic [RST_CNT_W-1:0] rst_cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 stalled;
    logic                 halt;
    logic                 wd_hit;
    logic                 launch;

    assign start_edge = start & ~start_q;
    assign cnt_inc    = (&cycle_count) ? cycle_count : cycle_count + 1'b1;

    // ------------------------------------------------------------------
    // Halt detection
    // ------------------------------------------------------------------
    if (HALT_MODE == 1) begin : g_stall
        pc_stall_det #(
            .PC_W         (PC_W),
            .STALL_CYCLES (STALL_CYCLES)
        ) u_stall (
            .clk     (clk),
            .rst     (rst),
            .run     (state == ST_RUN),
            .pc      (pc),
            .stalled (stalled)
        );
    end else begin : g_no_stall
        assign stalled = 1'b0;
    end

    assign halt = (pc == DONE_PC) || stalled;

`ifdef RUN_WATCHDOG_EN
    // Fires on the RUN cycle whose count would reach MAX_CYCLES; a halt in the
    // same cycle still ends with timeout set.
    assign wd_hit = (state == ST_RUN) && (cnt_inc == MAX_CYCLES);
`else
    assign wd_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    state_next = ST_RESET_CORE;
                    launch     = 1'b1;
                end
            end
            ST_RESET_CORE: begin
                if (rst_cnt == '0)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                // start edges are deliberately ignored while running.
                if (halt || wd_hit)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                if (start_edge) begin
                    state_next = ST_RESET_CORE;
                    launch     = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: start edge, reset-phase counter, run-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q     <= 1'b0;
            rst_cnt     <= '0;
            cycle_count <= '0;
        end else begin
            start_q <= start;
            if (launch) begin
                // Counter holds the remaining reset cycles after this one.
                rst_cnt     <= RST_CNT_W'(RST_CYCLES - 1);
                cycle_count <= '0;
            end else begin
                if (state == ST_RESET_CORE && rst_cnt != '0)
                    rst_cnt <= rst_cnt - 1'b1;
                if (state == ST_RUN)
                    cycle_count <= cnt_inc;
            end
        end
    end

`ifdef RUN_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout <= 1'b0;
        else if (launch)
            timeout <= 1'b0;
        else if (wd_hit)
            timeout <= 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs decoded from the state register: core_rst asserts as soon as
    // rst forces the state back to IDLE, with no dependence on pc.
    // ------------------------------------------------------------------
    assign core_rst = (state != ST_RUN);
    assign busy     = (state == ST_RESET_CORE) || (state == ST_RUN);
    assign done     = (state == ST_DONE);

endmodule : run_ctrl
